// File: rtl/arb_requester.sv
// Queued memory requester: buffers client commands, requests an arbiter
// grant per command and keeps one memory transaction in flight at a time.
module arb_requester #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_cmd_ready,
  output logic                  o_request,
  input  logic                  i_grant,
  output logic                  o_mem_valid,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_error,
  output logic                  o_busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [PW-1:0] ONE_PTR   = PW'(1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] ONE_WAIT  = TW'(1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ISSUE,
    WAIT_RSP
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   wait_q, wait_d;
  cmd_t            fifo_q [FIFO_DEPTH];

  logic            cmd_ready_q, cmd_ready_d;
  logic            request_q, request_d;
  logic            mem_valid_q, mem_valid_d;
  cmd_t            mem_cmd_q, mem_cmd_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;

  cmd_t            head;
  cmd_t            cmd_in;
  logic            push;
  logic            pop;
  logic            more;
  state_e          after_pop;

  always_comb begin
    cmd_in = '{
      write: i_cmd_write,
      addr:  i_cmd_addr,
      wdata: i_cmd_wdata
    };
    head = fifo_q[rd_ptr_q];
    push = i_cmd_valid && cmd_ready_q;
    // a same-cycle push is not counted; IDLE picks it up next cycle
    more = count_q > ONE_CNT;
    after_pop = more ? REQ : IDLE;
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pop         = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    error_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0)
          state_d = REQ;
      end
      REQ: begin
        if (i_grant)
          state_d = ISSUE;
      end
      ISSUE: begin
        if (i_mem_ready) begin
          if (head.write) begin
            pop     = 1'b1;
            state_d = after_pop;
          end else begin
            state_d = WAIT_RSP;
            wait_d  = '0;
          end
        end
      end
      WAIT_RSP: begin
        if (i_mem_rvalid) begin
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = i_mem_rdata;
          state_d     = after_pop;
        end else begin
          if (wait_q != WAIT_MAX)
            wait_d = wait_q + ONE_WAIT;
          if (wait_q == WAIT_LAST) begin
            pop     = 1'b1;
            error_d = 1'b1;
            state_d = after_pop;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ONE_PTR : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ONE_PTR : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    cmd_ready_d = count_d != FULL_CNT;
    request_d   = state_d == REQ;
    mem_valid_d = state_d == ISSUE;
    mem_cmd_d   = (state_d == ISSUE) ? head : '0;
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      cmd_ready_q <= 1'b0;
      request_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_cmd_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      cmd_ready_q <= cmd_ready_d;
      request_q   <= request_d;
      mem_valid_q <= mem_valid_d;
      mem_cmd_q   <= mem_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      fifo_q[wr_ptr_q] <= cmd_in;
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_request   = request_q;
  assign o_mem_valid = mem_valid_q;
  assign o_mem_write = mem_cmd_q.write;
  assign o_mem_addr  = mem_cmd_q.addr;
  assign o_mem_wdata = mem_cmd_q.wdata;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_error     = error_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed scenarios plus random traffic for arb_requester, checked
// every cycle against a queue-based transaction model.
module tb_arb_requester;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } mcmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic          o_cmd_ready, o_request, i_grant;
  logic          o_mem_valid, o_mem_write;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ready, i_mem_rvalid;
  logic [DW-1:0] i_mem_rdata;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_data;
  logic          o_error, o_busy;

  always #5 clk = ~clk;

  arb_requester #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .o_cmd_ready(o_cmd_ready),
    .o_request(o_request),
    .i_grant(i_grant),
    .o_mem_valid(o_mem_valid),
    .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready),
    .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data),
    .o_error(o_error),
    .o_busy(o_busy)
  );

  // model: pending command queue plus the phase of the head command
  // (0 idle, 1 requesting, 2 on the bus, 3 awaiting read data)
  mcmd_t         mq[$];
  int            ph;
  int            waited;
  logic          e_req, e_mval, e_mw, e_rv, e_err, e_busy, e_rdy;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwd, e_rd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mcmd_t pend[$];
  int    addr_log[$];
  int    data_log[$];
  int    acc_log[$];
  int    req_cyc, mval_cyc, rsp_cnt, err_cnt, err_cyc, first_req;
  logic [DW-1:0] last_rsp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit    take;
    bit    done;
    int    nph;
    mcmd_t c;
    if (rst) begin
      mq.delete();
      ph = 0;
      waited = 0;
      e_rv = 0;
      e_err = 0;
      e_rd = '0;
      e_rdy = 0;
    end else begin
      take = i_cmd_valid && e_rdy;
      done = 0;
      nph = ph;
      e_rv = 0;
      e_err = 0;
      case (ph)
        0: if (mq.size() > 0) nph = 1;
        1: if (i_grant) nph = 2;
        2: if (i_mem_ready) begin
             if (mq[0].w) done = 1;
             else begin
               nph = 3;
               waited = 0;
             end
           end
        3: if (i_mem_rvalid) begin
             done = 1;
             e_rv = 1;
             e_rd = i_mem_rdata;
           end else begin
             waited++;
             if (waited == TMO) begin
               done = 1;
               e_err = 1;
             end
           end
        default: nph = 0;
      endcase
      if (done) begin
        nph = (mq.size() - 1 > 0) ? 1 : 0;
        void'(mq.pop_front());
      end
      if (take) begin
        c.w = i_cmd_write;
        c.a = i_cmd_addr;
        c.d = i_cmd_wdata;
        mq.push_back(c);
      end
      ph = nph;
      e_rdy = mq.size() < DEPTH;
    end
    e_req  = ph == 1;
    e_mval = ph == 2;
    e_mw    = (ph == 2) ? mq[0].w : 1'b0;
    e_maddr = (ph == 2) ? mq[0].a : '0;
    e_mwd   = (ph == 2) ? mq[0].d : '0;
    e_busy = (ph != 0) || (mq.size() != 0);
  endtask

  task automatic check_all();
    chk("cmd_ready", o_cmd_ready, e_rdy);
    chk("request", o_request, e_req);
    chk("mem_valid", o_mem_valid, e_mval);
    chk("mem_write", o_mem_write, e_mw);
    chk("mem_addr", o_mem_addr, e_maddr);
    chk("mem_wdata", o_mem_wdata, e_mwd);
    chk("rsp_valid", o_rsp_valid, e_rv);
    chk("rsp_data", o_rsp_data, e_rd);
    chk("error", o_error, e_err);
    chk("busy", o_busy, e_busy);
  endtask

  task automatic drive_cycle(input bit cv, input bit cw,
                             input logic [AW-1:0] ca,
                             input logic [DW-1:0] cd,
                             input bit g, input bit mr, input bit rv,
                             input logic [DW-1:0] rd);
    i_cmd_valid  = cv;
    i_cmd_write  = cw;
    i_cmd_addr   = ca;
    i_cmd_wdata  = cd;
    i_grant      = g;
    i_mem_ready  = mr;
    i_mem_rvalid = rv;
    i_mem_rdata  = rd;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    cyc++;
  endtask

  task automatic clear_obs();
    addr_log.delete();
    data_log.delete();
    acc_log.delete();
    req_cyc = 0;
    mval_cyc = 0;
    rsp_cnt = 0;
    err_cnt = 0;
    err_cyc = -1;
    first_req = -1;
    last_rsp = '0;
  endtask

  // acts as client, arbiter and memory; pushes whatever is in pend
  task automatic serve(input int n, input int gdelay, input int rdelay,
                       input logic [DW-1:0] rdat, input bit mrdy);
    int    gw;
    int    age;
    bit    g, rv, cv;
    mcmd_t pc;
    gw = 0;
    age = -1;
    repeat (n) begin
      if (o_request) req_cyc++;
      if (o_mem_valid) mval_cyc++;
      if (o_rsp_valid) begin
        rsp_cnt++;
        last_rsp = o_rsp_data;
      end
      if (o_error) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (o_request && first_req < 0) first_req = cyc;
      g = o_request && (gw >= gdelay);
      gw = o_request ? gw + 1 : 0;
      if (age >= 0) age++;
      rv = (rdelay >= 0) && (age == rdelay);
      if (o_mem_valid && mrdy) begin
        addr_log.push_back(int'(o_mem_addr));
        data_log.push_back(int'(o_mem_wdata));
        acc_log.push_back(cyc);
        age = o_mem_write ? -1 : 0;
      end
      cv = pend.size() != 0;
      pc = cv ? pend[0] : '0;
      if (cv && o_cmd_ready) void'(pend.pop_front());
      drive_cycle(cv, pc.w, pc.a, pc.d, g, mrdy, rv, rdat);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_cycle(0, 0, '0, '0, 0, 0, 0, '0);
    drive_cycle(1, 1, 8'h77, 16'h1, 1, 1, 1, '0);
    chk("rst_ready", o_cmd_ready, 1'b0);
    rst = 1'b0;
    drive_cycle(0, 0, '0, '0, 0, 0, 0, '0);
    chk("post_rst_ready", o_cmd_ready, 1'b1);
    chk("post_rst_busy", o_busy, 1'b0);

    clear_obs();
    pend.push_back('{1'b1, 8'h10, 16'hBEEF});
    serve(10, 0, -1, '0, 1'b1);
    chk("wr_req_cycles", req_cyc, 1);
    chk("wr_mval_cycles", mval_cyc, 1);
    chk("wr_issued", addr_log.size(), 1);
    if (addr_log.size() > 0) begin
      chk("wr_addr", addr_log[0], 32'h10);
      chk("wr_wdata", data_log[0], 32'hBEEF);
    end
    chk("wr_busy", o_busy, 1'b0);

    clear_obs();
    pend.push_back('{1'b0, 8'h22, 16'h0});
    serve(30, 10, 2, 16'h1234, 1'b1);
    chk("starve_req_cycles", req_cyc, 11);
    chk("starve_rsp_pulses", rsp_cnt, 1);
    chk("starve_rsp_data", last_rsp, 16'h1234);

    clear_obs();
    for (int i = 0; i < 5; i++)
      pend.push_back('{1'b1, AW'(8'h40 + i), DW'(16'h100 + i)});
    serve(12, 0, -1, '0, 1'b0);
    chk("full_ready", o_cmd_ready, 1'b0);
    chk("full_pending", pend.size(), 1);
    serve(40, 0, -1, '0, 1'b1);
    chk("full_issued", addr_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < addr_log.size())
        chk("full_order", addr_log[i], 32'h40 + i);

    clear_obs();
    pend.push_back('{1'b0, 8'h30, 16'h0});
    pend.push_back('{1'b1, 8'h31, 16'h5A5A});
    serve(60, 0, -1, '0, 1'b1);
    chk("tmo_err_pulses", err_cnt, 1);
    chk("tmo_rsp_pulses", rsp_cnt, 0);
    chk("tmo_issued", addr_log.size(), 2);
    if (acc_log.size() > 0)
      chk("tmo_latency", err_cyc - acc_log[0], TMO + 1);
    if (addr_log.size() > 1)
      chk("tmo_next_addr", addr_log[1], 32'h31);

    clear_obs();
    pend.push_back('{1'b0, 8'h50, 16'h0});
    serve(8, 0, -1, '0, 1'b1);
    chk("midwait_busy", o_busy, 1'b1);
    rst = 1'b1;
    drive_cycle(0, 0, '0, '0, 0, 0, 0, '0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, '0, '0, 0, 1, 1, 16'hDEAD);
      chk("late_rv_rsp", o_rsp_valid, 1'b0);
      chk("late_rv_err", o_error, 1'b0);
    end
    chk("late_rv_ready", o_cmd_ready, 1'b1);
    chk("late_rv_busy", o_busy, 1'b0);

    clear_obs();
    for (int i = 0; i < 3; i++)
      pend.push_back('{1'b1, AW'(8'h60 + i), DW'(16'h200 + i)});
    serve(20, 0, -1, '0, 1'b1);
    chk("b2b_issued", addr_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("b2b_span", acc_log[2] - first_req + 1, 6);
      for (int i = 0; i < 3; i++)
        chk("b2b_order", addr_log[i], 32'h60 + i);
    end

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  AW'($urandom), DW'($urandom),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), DW'($urandom));
    end
    rst = 1'b0;
    serve(60, 0, 1, 16'h4321, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, address bits; DATA_WIDTH, default 16, data bits; FIFO_DEPTH, default 4, command entries, power of two ≥2; TIMEOUT, default 15, read-response wait limit in cycles, ≥1.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  client command, with 1 = write.
REQ-005 o_cmd_ready  output  1  command slot free.
REQ-006 o_request  output  1  request line to the round-robin arbiter.
REQ-007 i_grant  input  1  this port's arbiter grant bit, combinational from o_request, valid in the same cycle.
REQ-008 o_mem_valid, o_mem_write, o_mem_addr, o_mem_wdata  output  1/1/ADDR_WIDTH/DATA_WIDTH  memory transaction.
REQ-009 i_mem_ready  input  1  memory accepts the transaction this cycle.
REQ-010 i_mem_rvalid, i_mem_rdata  input  1/DATA_WIDTH  read response.
REQ-011 o_rsp_valid, o_rsp_data  output  1/DATA_WIDTH  read data to the client, one-cycle pulse.
REQ-012 o_error  output  1  one-cycle pulse on read timeout.
REQ-013 o_busy  output  1  FSM not in IDLE or FIFO non-empty.

Function
REQ-014 The command FIFO SHALL hold FIFO_DEPTH entries, with o_cmd_ready = !full.
REQ-015 A push SHALL occur on i_cmd_valid && o_cmd_ready.
REQ-016 A simultaneous push and pop SHALL leave the count unchanged.
REQ-017 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, REQ, ISSUE, WAIT_RSP.
REQ-019 IDLE: o_request=0 and o_mem_valid=0; the FSM SHALL go to REQ in the cycle after the FIFO becomes non-empty, giving at least one cycle push-to-request latency.
REQ-020 REQ: o_request=1; on i_grant=1 the FSM SHALL go to ISSUE next cycle, and on i_grant=0 it SHALL stay in REQ with o_request held high with no timeout.
REQ-021 ISSUE: o_request=0 and o_mem_valid=1, with fields from the FIFO head, and these fields SHALL remain stable until i_mem_ready.
REQ-022 ISSUE, on i_mem_ready with a write: the FIFO SHALL pop; the next state SHALL be REQ if entries remain after the pop, otherwise IDLE.
REQ-023 ISSUE, on i_mem_ready with a read: the FSM SHALL go to WAIT_RSP, clear the wait counter, and leave the head unpopped.
REQ-024 WAIT_RSP, on i_mem_rvalid: o_rsp_valid=1 for exactly one cycle in the next cycle, with o_rsp_data = captured i_mem_rdata.
REQ-025 WAIT_RSP, on i_mem_rvalid: the FIFO SHALL pop, with the next state chosen as in REQ-022.
REQ-026 WAIT_RSP: a counter SHALL increment each cycle without rvalid.
REQ-027 When the count reaches TIMEOUT without rvalid, o_error SHALL pulse for one cycle in the next cycle, o_rsp_valid SHALL stay 0, and the FIFO SHALL pop, with the next state chosen as in REQ-022.
REQ-028 i_grant outside REQ SHALL be ignored.
REQ-029 i_mem_ready outside ISSUE SHALL be ignored.
REQ-030 i_mem_rvalid outside WAIT_RSP SHALL be ignored.
REQ-031 Only one transaction SHALL be outstanding at a time.
REQ-032 Commands SHALL be issued in FIFO order.
REQ-033 Timeout-counter width SHALL be $clog2(TIMEOUT+1); the counter SHALL saturate and never wrap.
REQ-034 A push into an empty FIFO in the same cycle a pop empties it SHALL be handled as a non-empty FIFO in the next cycle.

Reset
REQ-035 While rst=1 at a rising edge, the block SHALL empty the FIFO, set the FSM to IDLE, and clear the timeout counter.
REQ-036 While rst=1, all outputs SHALL be 0, except o_cmd_ready, which SHALL be 1 in the cycle after reset deasserts.
REQ-037 Reset asserted in any state, including mid-ISSUE or mid-WAIT_RSP, SHALL abandon the transaction without issuing o_rsp_valid or o_error.
REQ-038 A late i_mem_rvalid after reset SHALL be ignored.

Verification
REQ-039 Write, immediate grant: push write addr=0x10 data=0xBEEF; i_grant=1 when requested; i_mem_ready=1 -> o_request high 1 cycle; o_mem_valid 1 cycle with addr 0x10 and wdata 0xBEEF; FSM back in IDLE; o_busy=0.
REQ-040 Grant starvation: push read 0x22; hold i_grant=0 for 10 cycles, then 1; rvalid with 0x1234 two cycles after accept -> o_request held 11 cycles; o_rsp_valid one pulse with 0x1234.
REQ-041 FIFO full: push 4 commands with memory stalled (i_mem_ready=0) -> o_cmd_ready=0 after the 4th; 5th valid not accepted; all 4 issued in order once ready returns.
REQ-042 Timeout: read issued; rvalid never asserted -> o_error pulses exactly once, TIMEOUT+1 cycles after accept; no o_rsp_valid; next queued command proceeds.
REQ-043 Reset mid-WAIT_RSP: assert rst for 1 cycle; drive rvalid afterward -> no o_rsp_valid or o_error; FIFO empty; o_cmd_ready=1.
REQ-044 Back-to-back: 3 writes queued -> FSM goes ISSUE->REQ directly with no IDLE bubble; grants consumed in order.
